// File: rtl/ula_pkg.sv
// Shared definitions for the ULA multiply path: FSM state encoding and default operand width.
package ula_pkg;

  localparam int MUL_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/somador_mult.sv
// WIDTH-bit unsigned adder with carry-out; forms the partial-product sum of the multiplier.
module somador_mult #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/multiplicador_sequencial.sv
// Unsigned shift-add multiplier: one partial product per clock, start/done handshake,
// product registered and held between operations.
module multiplicador_sequencial
  import ula_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t           state, state_n;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_n;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum_lo;
  logic                 sum_co;
  logic                 load;
  logic                 last;

  assign addend = acc[0] ? mcand : '0;

  somador_mult #(.WIDTH(WIDTH)) u_somador (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .s    (sum_lo),
    .cout (sum_co)
  );

  // Right shift keeps the adder carry as the new MSB.
  assign acc_n = {sum_co, sum_lo, acc[WIDTH-1:1]};

  always_comb begin
    state_n = state;
    load    = 1'b0;
    last    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == CW'(1)) begin
          last    = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_CALC;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= CW'(WIDTH);
    end else if (state == ST_CALC) begin
      acc <= acc_n;
      cnt <= cnt - CW'(1);
      if (last) begin
        res_q <= acc_n;
      end
    end
  end

  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);
  assign res  = res_q;

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed and random checks of the sequential multiplier: latency, result hold,
// back-to-back operation, ignored start during CALC, and asynchronous reset abort.
module tb_multiplicador_sequencial;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] res;

  int n_cmp;
  int n_err;

  multiplicador_sequencial #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation from a negedge, scrambles operands after accept, and waits for done.
  task automatic do_mul(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic [15:0] r,
                        output logic busy_acc, output logic [15:0] res_acc,
                        output logic overlap);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    busy_acc = busy;
    res_acc  = res;
    overlap  = busy & done;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      overlap = overlap | (busy & done);
    end
    r = res;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, res} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b res=%0d, required 0 0 0", busy, done, res);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_max;
    int lat; logic [15:0] r; logic ba; logic [15:0] ra; logic ov;
    do_mul(8'd255, 8'd255, lat, r, ba, ra, ov);
    n_cmp++;
    if (ba !== 1'b1) begin
      n_err++;
      $display("FAIL max_busy_after_accept: got %b, required 1", ba);
    end
    n_cmp++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL max_latency: got %0d, required 8", lat);
    end
    n_cmp++;
    if (r !== 16'hFE01) begin
      n_err++;
      $display("FAIL max_product: got %h, required fe01", r);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_one_cycle: got %b, required 0", done);
    end
  endtask

  task automatic test_zero_one;
    int lat; logic [15:0] r; logic ba; logic [15:0] ra; logic ov;
    do_mul(8'd0, 8'd173, lat, r, ba, ra, ov);
    n_cmp++;
    if (lat !== 8 || r !== 16'd0) begin
      n_err++;
      $display("FAIL zero_operand: lat=%0d res=%0d, required lat=8 res=0", lat, r);
    end
    do_mul(8'd1, 8'd200, lat, r, ba, ra, ov);
    n_cmp++;
    if (ra !== 16'd0) begin
      n_err++;
      $display("FAIL res_hold_during_calc: got %0d, required 0", ra);
    end
    n_cmp++;
    if (lat !== 8 || r !== 16'd200) begin
      n_err++;
      $display("FAIL one_operand: lat=%0d res=%0d, required lat=8 res=200", lat, r);
    end
    a = 8'd3;
    b = 8'd3;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (res !== 16'd200) begin
      n_err++;
      $display("FAIL res_hold_idle: got %0d, required 200", res);
    end
    do_mul(8'd2, 8'd2, lat, r, ba, ra, ov);
    n_cmp++;
    if (ra !== 16'd200 || r !== 16'd4) begin
      n_err++;
      $display("FAIL res_hold_next_op: during=%0d final=%0d, required 200 then 4", ra, r);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; int d1; int d2; int bad_idle;
    logic [15:0] r1; logic [15:0] r2; logic b_acc2; logic ov;
    @(negedge clk);
    start = 1'b1;
    a = 8'd12;
    b = 8'd10;
    @(negedge clk);
    a = 8'd7;
    b = 8'd9;
    cyc = 0; d1 = -1; d2 = -1; bad_idle = 0; ov = 1'b0;
    r1 = '0; r2 = '0; b_acc2 = 1'b0;
    while (d2 < 0 && cyc < 40) begin
      ov = ov | (busy & done);
      if (!busy && !done) bad_idle++;
      if (done && d1 < 0) begin
        d1 = cyc;
        r1 = res;
      end else if (done) begin
        d2 = cyc;
        r2 = res;
      end
      @(negedge clk);
      cyc++;
      if (cyc == d1 + 1 && d1 >= 0) begin
        start = 1'b0;
        b_acc2 = busy;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (d1 !== 8 || r1 !== 16'd120) begin
      n_err++;
      $display("FAIL b2b_first: cycle=%0d res=%0d, required 8 and 120", d1, r1);
    end
    n_cmp++;
    if (d2 - d1 !== 9 || r2 !== 16'd63) begin
      n_err++;
      $display("FAIL b2b_second: gap=%0d res=%0d, required 9 and 63", d2 - d1, r2);
    end
    n_cmp++;
    if (b_acc2 !== 1'b1 || bad_idle !== 0 || ov !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_busy: busy_after_reaccept=%b idle_cycles=%0d overlap=%b, required 1 0 0",
               b_acc2, bad_idle, ov);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int cyc; int ndone; int first;
    @(negedge clk);
    start = 1'b1;
    a = 8'd13;
    b = 8'd11;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; ndone = 0; first = -1;
    while (cyc < 20) begin
      if (cyc == 3) begin
        start = 1'b1;
        a = 8'd5;
        b = 8'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first < 0) first = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (ndone !== 1 || first !== 8) begin
      n_err++;
      $display("FAIL ignore_start_done: pulses=%0d first=%0d, required 1 at 8", ndone, first);
    end
    n_cmp++;
    if (res !== 16'd143) begin
      n_err++;
      $display("FAIL ignore_start_res: got %0d, required 143", res);
    end
  endtask

  task automatic test_async_reset;
    int cyc; int ndone; int lat; logic [15:0] r; logic ba; logic [15:0] ra; logic ov;
    @(negedge clk);
    start = 1'b1;
    a = 8'd100;
    b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || res !== 16'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b done=%b res=%0d, required 0 0 0", busy, done, res);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; ndone = 0;
    while (cyc < 12) begin
      if (done) ndone++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (ndone !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: pulses=%0d busy=%b, required 0 0", ndone, busy);
    end
    do_mul(8'd100, 8'd3, lat, r, ba, ra, ov);
    n_cmp++;
    if (lat !== 8 || r !== 16'd300) begin
      n_err++;
      $display("FAIL after_reset_op: lat=%0d res=%0d, required 8 300", lat, r);
    end
  endtask

  task automatic test_random;
    int lat; logic [15:0] r; logic ba; logic [15:0] ra; logic ov;
    logic [7:0] x; logic [7:0] y; logic [15:0] expv;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      expv = 16'(x) * 16'(y);
      do_mul(x, y, lat, r, ba, ra, ov);
      n_cmp++;
      if (r !== expv || lat !== 8 || ov !== 1'b0) begin
        n_err++;
        $display("FAIL random_%0d: a=%0d b=%0d res=%0d lat=%0d overlap=%b, required res=%0d lat=8 overlap=0",
                 i, x, y, r, lat, ov, expv);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    test_reset();
    test_max();
    test_zero_one();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
